// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared constants, types and helpers for the 4-digit
//             7-segment scan logic.
//  Contents : DIGITS, AN_OFF, AN_RESET, BCD_MAX, bcd_t, scan_out_t,
//             bcd_invalid(), an_for()
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  localparam int         DIGITS   = 4;
  localparam logic [3:0] AN_OFF   = 4'b1111;  // all common anodes dark
  localparam logic [3:0] AN_RESET = 4'b1110;  // digit 0 selected
  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef logic [3:0] bcd_t;

  // Next-cycle values for the registered display outputs
  typedef struct packed {
    logic [3:0] an;
    bcd_t       digit;
    logic       err;
  } scan_out_t;

  function automatic logic bcd_invalid(input bcd_t d);
    return (d > BCD_MAX);
  endfunction

  // Active-low one-cold anode pattern for digit slot i
  function automatic logic [3:0] an_for(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_refresh_tick.sv
`default_nettype none
// ============================================================================
//  Module   : seg_refresh_tick
//  Purpose  : Free-running prescaler producing a one-cycle tick every
//             REFRESH_DIV clocks, used to pace display multiplexing.
//  Params   : REFRESH_DIV  clock cycles per tick period (>= 2)
//  Ports    : clk   in   system clock
//             rst   in   synchronous active-high reset
//             tick  out  high on the last cycle of each period
//  Revision : 1.0  initial release
// ============================================================================
module seg_refresh_tick
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] pcnt;

  // Explicit wrap so non-power-of-two dividers count 0 .. REFRESH_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CW'(1);
    end
  end

  // Decoded from the counter so the tick lines up with the wrap cycle
  assign tick = (pcnt == LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Purpose  : Four-digit time-multiplexed scan controller feeding a
//             BCD-to-7-segment decoder and active-low common anodes.
//             Holds a packed-BCD value, scans one digit per slot, with
//             optional leading-zero blanking and invalid-BCD detection.
//  Params   : REFRESH_DIV  clock cycles per digit slot (>= 2)
//  Ports    : clk       in   system clock
//             rst       in   synchronous active-high reset
//             value     in   [15:0] packed BCD, [3:0] = rightmost digit
//             load      in   capture value into the hold register
//             blank_lz  in   enable leading-zero blanking
//             w,x,y,z   out  current digit bits 3..0 to the decoder
//             an        out  [3:0] anode enables, active low
//             bcd_err   out  any held nibble above 9
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an,
  output logic        bcd_err
);

  logic              tick;
  logic [15:0]       held;
  logic [15:0]       held_next;
  logic [1:0]        idx;
  logic [1:0]        idx_next;
  logic [DIGITS-1:0] nib_bad;
  logic [DIGITS-1:0] upper_zero;
  bcd_t              cur_digit;
  logic              blank;
  scan_out_t         nxt;

  seg_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Everything downstream looks at the post-edge hold/index values so a
  // load shows up one edge later on whichever slot becomes current, and a
  // load coinciding with a tick lands directly in the new slot.
  always_comb begin
    held_next = load ? value : held;
    idx_next  = idx + {1'b0, tick};
  end

  // Per-nibble flags: invalid BCD, and "this nibble and all above are zero"
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
      assign nib_bad[i]    = bcd_invalid(held_next[4*i +: 4]);
      assign upper_zero[i] = (held_next[15:4*i] == '0);
    end
  endgenerate

  always_comb begin
    cur_digit = held_next[{idx_next, 2'b00} +: 4];
    // Digit 0 never leading-zero blanks so a zero value still shows "0"
    blank     = nib_bad[idx_next]
              | (blank_lz & (idx_next != 2'd0) & upper_zero[idx_next]);
    nxt.an    = blank ? AN_OFF : an_for(idx_next);
    nxt.digit = blank ? bcd_t'(4'b0000) : cur_digit;
    nxt.err   = |nib_bad;
  end

  // Anode and digit bits share one register stage so they switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      held         <= '0;
      idx          <= 2'd0;
      {w, x, y, z} <= 4'b0000;
      an           <= AN_RESET;
      bcd_err      <= 1'b0;
    end else begin
      held         <= held_next;
      idx          <= idx_next;
      {w, x, y, z} <= nxt.digit;
      an           <= nxt.an;
      bcd_err      <= nxt.err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_mux
//  Purpose  : Scoreboard bench for seg_scan_mux with REFRESH_DIV = 4.
//             A driver issues directed and random stimulus and pushes the
//             expected display state; a monitor pops and compares on the
//             falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_mux;

  localparam int DIV = 4;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [15:0] value    = 16'h0000;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic        w, x, y, z;
  logic [3:0]  an;
  logic        bcd_err;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .w        (w),
    .x        (x),
    .y        (y),
    .z        (z),
    .an       (an),
    .bcd_err  (bcd_err)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] dig;
    logic       err;
    int         step;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   m_held = 0;   // model of the displayed value
  int   m_cyc  = 0;   // cycles since the reset state appeared
  int   stepno = 0;

  // Reference: slot = elapsed cycles / DIV, modulo 4 digits
  function automatic exp_t model_out(input int held, input int cyc, input logic blz);
    exp_t e;
    int   s;
    int   d;
    int   above;
    bit   any_bad;
    bit   blank;
    s       = (cyc / DIV) % 4;
    above   = held >> (4 * s);
    d       = above % 16;
    any_bad = 0;
    for (int k = 0; k < 4; k++)
      if (((held >> (4 * k)) % 16) > 9) any_bad = 1;
    blank   = (d > 9) || (blz && s != 0 && above == 0);
    e.an    = blank ? 4'hF : 4'(15 - (1 << s));
    e.dig   = blank ? 4'h0 : 4'(d);
    e.err   = any_bad;
    e.step  = 0;
    return e;
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic b);
    exp_t e;
    @(negedge clk);
    #1;
    rst      = r;
    load     = l;
    value    = v;
    blank_lz = b;
    if (r) begin
      m_held = 0;
      m_cyc  = 0;
      e.an   = 4'b1110;
      e.dig  = 4'h0;
      e.err  = 1'b0;
    end else begin
      if (l) m_held = int'(v);
      m_cyc++;
      e = model_out(m_held, m_cyc, b);
    end
    stepno++;
    e.step = stepno;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), b);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    int          n;
    v = 16'h0000;
    n = $urandom_range(0, 4);
    for (int k = 0; k < n; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (an !== e.an) begin
        fails++;
        $display("FAIL an step=%0d got=%b exp=%b", e.step, an, e.an);
      end
      tests++;
      if ({w, x, y, z} !== e.dig) begin
        fails++;
        $display("FAIL wxyz step=%0d got=%b exp=%b", e.step, {w, x, y, z}, e.dig);
      end
      tests++;
      if (bcd_err !== e.err) begin
        fails++;
        $display("FAIL bcd_err step=%0d got=%b exp=%b", e.step, bcd_err, e.err);
      end
    end
  end

  initial begin
    logic blz;
    // Reset for two cycles, then free-run a full scan and more
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    idle(20, 1'b0);
    // Plain scan
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(18, 1'b0);
    // Leading-zero blanking
    step(1'b0, 1'b1, 16'h0050, 1'b1);
    idle(17, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(17, 1'b1);
    // Invalid BCD, then repaired
    step(1'b0, 1'b1, 16'h12A4, 1'b0);
    idle(17, 1'b0);
    step(1'b0, 1'b1, 16'h1294, 1'b0);
    idle(6, 1'b0);
    // Load on the tick cycle
    while (((m_cyc + 1) % DIV) != 0) idle(1, 1'b0);
    step(1'b0, 1'b1, 16'h5678, 1'b0);
    idle(6, 1'b0);
    // Reset mid-slot with a simultaneous load
    idle(1, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 1'b0);
    idle(17, 1'b0);
    // Random traffic
    blz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) blz = ~blz;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), rand_value(), blz);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
# seg_scan_mux

Four-digit time-multiplexed scan controller that sits directly upstream of the BCD-to-7-segment decoder. It holds a 16-bit packed-BCD value and presents one digit at a time on the decoder's `w,x,y,z` inputs. In step with that, it drives the active-low common-anode enables of a 4-digit display. It also provides optional leading-zero blanking and invalid-BCD detection.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥ 2.
- `clk  in  1  system clock`
- `rst  in  1  synchronous, active-high reset`
- `value  in  16  packed BCD; [3:0] = digit 0 (rightmost), [15:12] = digit 3`
- `load  in  1  single-cycle strobe; captures `value` into the hold register`
- `blank_lz  in  1  enables leading-zero blanking; sampled every cycle`
- `w  out  1  current digit bit 3 (MSB) to the decoder`
- `x  out  1  current digit bit 2`
- `y  out  1  current digit bit 1`
- `z  out  1  current digit bit 0 (LSB)`
- `an  out  4  anode enables, active low; an[i] = 0 lights digit i`
- `bcd_err  out  1  high while any held nibble is > 9`

## Operation
- Hold register `held[15:0]`:
  - `held <= value` on any cycle with `load=1`.
  - Otherwise it keeps its value.
  - A `load` held high for several cycles reloads on every cycle it is high.
- Prescaler `pcnt`:
  - Width is `$clog2(REFRESH_DIV)`; it counts 0 .. REFRESH_DIV-1 and then wraps to 0.
  - `tick` is asserted on the cycle where `pcnt == REFRESH_DIV-1`.
- Digit index `idx[1:0]`:
  - Advances 0→1→2→3→0 on `tick`; it wraps naturally and no other state exists.
- Output function, evaluated on `idx_next` and `held_next`:
  - `{w,x,y,z} = held_next[4*idx_next +: 4]`.
  - Digit `i` is blanked if `blank_lz=1`, `i != 0`, and every nibble at positions ≥ `i` is 0.
  - Digit `i` is also blanked if its nibble is > 9.
  - Blanked: `an = 4'b1111` and `{w,x,y,z} = 4'b0000`.
  - Not blanked: `an = ~(4'b0001 << i)`.
  - Digit 0 is never blanked by leading-zero logic, so the value 0000 shows "0".
- `bcd_err` = OR over the 4 nibbles of (nibble > 9), computed on `held_next`.
- Simultaneous `load` and `tick`: the new digit slot shows the newly loaded value.
- Reset mid-operation:
  - All state returns to its reset value on the next edge, regardless of `load` or `tick`.
  - `rst` has priority over `load`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: `held=0`, `pcnt=0`, `idx=0`, `{w,x,y,z}=4'b0000`, `an=4'b1110`, `bcd_err=0`.
- Load latency:
  - `value` is visible on `w..z`, `an` and `bcd_err` on the edge after the cycle `load` is asserted.
  - This applies to whichever digit is currently selected.
- Slot length:
  - Each digit is selected for exactly REFRESH_DIV cycles.
  - A full scan is 4·REFRESH_DIV cycles.
  - After reset release, digit 0 lasts REFRESH_DIV cycles (its first cycle is the reset state), then digit 1 follows.
- `an` and `{w,x,y,z}` always change on the same edge, so no ghosting window is generated by this block.
- `blank_lz` changes take effect one cycle later.

## Structure
- Package `seg_pkg`:
  - `DIGITS = 4`
  - `AN_OFF = 4'b1111`
  - `BCD_MAX = 4'd9`
  - `typedef logic [3:0] bcd_t`
- Sub-module `seg_refresh_tick`:
  - Contents: parameter `REFRESH_DIV`, ports `clk`, `rst`, and output `tick`.
  - It is reusable by later display blocks.
- The remaining logic (hold register, index, blanking and output registers) lives in `seg_scan_mux`.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: assert `rst` for 2 cycles → `an=1110`, `wxyz=0000`, `bcd_err=0`. Then `an` steps to 1101 exactly 4 cycles after release, and 1011, 0111, 1110 at 4-cycle intervals.
- Scan: load 16'h1234 with `blank_lz=0` → digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1, each with the matching `an` bit low. The value appears one cycle after `load`.
- Blanking: load 16'h0050 with `blank_lz=1` → digits 2 and 3 have `an=1111`; digits 1 and 0 show 5 and 0. Load 16'h0000 → only digit 0 lit, showing 0.
- Invalid BCD: load 16'h12A4 → `bcd_err=1` one cycle after load, and digit 1 is blanked. Reload 16'h1294 → `bcd_err=0` next cycle.
- Collisions:
  - `load` coincident with `tick` → the new slot shows the new value.
  - `rst` asserted mid-slot together with `load` → reset values result and `held=0`.
